// File: rtl/hacd_decomp_rdbuf.sv
// Read-side staging buffer for the HACD page decompressor.
// Captures the R-channel beats of one compressed page into a line buffer
// and serves them to the decompressor with a 1-cycle read latency. The
// read pointer is loadable so the consumer can rewind or skip; lines stay
// resident until the next fill_start (no circular wrap).
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif

module hacd_decomp_rdbuf #(
  parameter int FIFO_PTR_WIDTH = 6,
  parameter int DATA_WIDTH     = `HACD_AXI4_DATA_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      fill_start,
  input  logic [13:0]               comp_size,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  input  logic [DATA_WIDTH-1:0]     axi_rdata,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rlast,
  input  logic [FIFO_PTR_WIDTH-1:0] rdfifo_rdptr,
  input  logic                      ld_rdfifo_rdptr,
  output logic                      rdfifo_empty,
  input  logic                      rd_req,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [1:0]                rd_rresp,
  output logic                      rd_valid,
  output logic                      fill_done,
  output logic [FIFO_PTR_WIDTH:0]   fill_cnt,
  output logic                      size_err,
  output logic                      len_err,
  output logic                      ptr_err
);

  localparam int DEPTH = 2**FIFO_PTR_WIDTH;
  localparam int BYTES = DATA_WIDTH/8;
  localparam int BSH   = $clog2(BYTES);
  localparam int PW    = FIFO_PTR_WIDTH + 1;
  localparam int EW    = DATA_WIDTH + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_HOLD} state_t;

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_wrptr, r_rdptr, r_expected;
  logic                r_fill_done, r_size_err, r_len_err, r_ptr_err;
  logic                r_rd_valid;
  logic [EW-1:0]       r_rd_line;
  logic [EW-1:0]       r_mem [DEPTH];

  logic [14:0]         w_size_rnd, w_exp_raw;
  logic                w_size_ovf;
  logic [PW-1:0]       w_exp;
  logic                w_rready, w_beat, w_empty, w_wr_last;
  logic [PW-1:0]       w_ld_val;
  logic                w_ld_ovr, w_rd_go;
  logic                w_done_set, w_len_set;

  // Expected beat count = ceil(comp_size/BYTES), clamped to DEPTH lines.
  assign w_size_rnd = {1'b0, comp_size} + 15'(BYTES - 1);
  assign w_exp_raw  = w_size_rnd >> BSH;
  assign w_size_ovf = w_exp_raw > 15'(DEPTH);
  assign w_exp      = w_size_ovf ? PW'(DEPTH) : w_exp_raw[PW-1:0];

  // rready is purely a function of registered state (no rvalid path).
  assign w_rready  = (r_state == ST_FILL) && (r_wrptr < r_expected);
  assign w_beat    = axi_rvalid && w_rready;
  assign w_wr_last = (r_wrptr + PW'(1)) == r_expected;
  assign w_empty   = (r_rdptr == r_wrptr);

  // A load beyond the pre-edge write pointer clamps to it (empty).
  assign w_ld_val  = {1'b0, rdfifo_rdptr};
  assign w_ld_ovr  = w_ld_val > r_wrptr;

  // Load and fill_start both override a same-cycle read request.
  assign w_rd_go   = rd_req && !w_empty && !ld_rdfifo_rdptr && !fill_start;

  // Next-state: fill_start restarts from any state; a beat may end the page.
  always_comb begin
    w_state_nxt = r_state;
    w_done_set  = 1'b0;
    w_len_set   = 1'b0;
    if (fill_start) begin
      w_state_nxt = (w_exp == '0) ? ST_HOLD : ST_FILL;
    end else if (w_beat) begin
      if (w_wr_last) begin
        w_state_nxt = ST_HOLD;
        w_done_set  = 1'b1;
      end else if (axi_rlast) begin
        w_state_nxt = ST_HOLD;
        w_done_set  = 1'b1;
        w_len_set   = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Pointers, status flags and the registered read port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrptr     <= '0;
      r_rdptr     <= '0;
      r_expected  <= '0;
      r_fill_done <= 1'b0;
      r_size_err  <= 1'b0;
      r_len_err   <= 1'b0;
      r_ptr_err   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_line   <= '0;
    end else if (fill_start) begin
      r_wrptr     <= '0;
      r_rdptr     <= '0;
      r_expected  <= w_exp;
      r_fill_done <= (w_exp == '0);
      r_size_err  <= w_size_ovf;
      r_len_err   <= 1'b0;
      r_ptr_err   <= 1'b0;
      r_rd_valid  <= 1'b0;
    end else begin
      if (w_beat)     r_wrptr     <= r_wrptr + PW'(1);
      if (w_done_set) r_fill_done <= 1'b1;
      if (w_len_set)  r_len_err   <= 1'b1;
      r_rd_valid <= w_rd_go;
      if (w_rd_go) r_rd_line <= r_mem[r_rdptr[FIFO_PTR_WIDTH-1:0]];
      if (ld_rdfifo_rdptr) begin
        r_rdptr <= w_ld_ovr ? r_wrptr : w_ld_val;
        if (w_ld_ovr) r_ptr_err <= 1'b1;
      end else if (w_rd_go) begin
        r_rdptr <= r_rdptr + PW'(1);
      end
    end
  end

  // Line storage: {rresp, rdata}; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (w_beat && !fill_start)
      r_mem[r_wrptr[FIFO_PTR_WIDTH-1:0]] <= {axi_rresp, axi_rdata};
  end

  assign axi_rready   = w_rready;
  assign rdfifo_empty = w_empty;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_line[DATA_WIDTH-1:0];
  assign rd_rresp     = r_rd_line[EW-1:DATA_WIDTH];
  assign fill_done    = r_fill_done;
  assign fill_cnt     = r_wrptr;
  assign size_err     = r_size_err;
  assign len_err      = r_len_err;
  assign ptr_err      = r_ptr_err;

endmodule

// File: tb/tb_hacd_decomp_rdbuf.sv
// Bench for hacd_decomp_rdbuf: directed page scenarios plus randomized
// traffic, checked every cycle against a page-level model.
module tb_hacd_decomp_rdbuf;
  localparam int PTRW = 6;
  localparam int DW   = 512;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           fill_start = 1'b0;
  logic [13:0]    comp_size = '0;
  logic           axi_rvalid = 1'b0;
  logic           axi_rready;
  logic [DW-1:0]  axi_rdata = '0;
  logic [1:0]     axi_rresp = '0;
  logic           axi_rlast = 1'b0;
  logic [PTRW-1:0] rdfifo_rdptr = '0;
  logic           ld = 1'b0;
  logic           rdfifo_empty;
  logic           rd_req = 1'b0;
  logic [DW-1:0]  rd_data;
  logic [1:0]     rd_rresp;
  logic           rd_valid;
  logic           fill_done;
  logic [PTRW:0]  fill_cnt;
  logic           size_err, len_err, ptr_err;

  int n_checks = 0;
  int n_fail   = 0;

  hacd_decomp_rdbuf #(.FIFO_PTR_WIDTH(PTRW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .fill_start(fill_start), .comp_size(comp_size),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .rdfifo_rdptr(rdfifo_rdptr),
    .ld_rdfifo_rdptr(ld), .rdfifo_empty(rdfifo_empty), .rd_req(rd_req),
    .rd_data(rd_data), .rd_rresp(rd_rresp), .rd_valid(rd_valid),
    .fill_done(fill_done), .fill_cnt(fill_cnt), .size_err(size_err),
    .len_err(len_err), .ptr_err(ptr_err)
  );

  always #5 clk = ~clk;

  // ---------------- page-level model ----------------
  int            m_wr, m_rd, m_exp;
  bit            m_filling, m_done, m_serr, m_lerr, m_perr, m_rvld;
  logic [DW+1:0] m_mem [64];
  logic [DW+1:0] m_rdat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr = 0; m_rd = 0; m_exp = 0; m_filling = 0; m_done = 0;
      m_serr = 0; m_lerr = 0; m_perr = 0; m_rvld = 0; m_rdat = '0;
    end else if (fill_start) begin
      m_wr = 0; m_rd = 0; m_lerr = 0; m_perr = 0; m_rvld = 0;
      m_exp = (int'(comp_size) + 63) / 64;
      m_serr = (m_exp > 64);
      if (m_serr) m_exp = 64;
      m_filling = (m_exp != 0);
      m_done = (m_exp == 0);
    end else begin
      int  wr0;
      bit  acc, rdgo;
      wr0  = m_wr;
      acc  = axi_rvalid && m_filling && (m_wr < m_exp);
      rdgo = rd_req && (m_rd != wr0) && !ld;
      m_rvld = rdgo;
      if (rdgo) begin
        m_rdat = m_mem[m_rd];
        m_rd++;
      end
      if (ld) begin
        if (int'(rdfifo_rdptr) > wr0) begin m_rd = wr0; m_perr = 1; end
        else m_rd = int'(rdfifo_rdptr);
      end
      if (acc) begin
        m_mem[m_wr] = {axi_rresp, axi_rdata};
        m_wr++;
        if (m_wr == m_exp) begin m_filling = 0; m_done = 1; end
        else if (axi_rlast) begin m_filling = 0; m_done = 1; m_lerr = 1; end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("status",
          64'({axi_rready, rdfifo_empty, fill_done, fill_cnt, size_err, len_err, ptr_err, rd_valid}),
          64'({(m_filling && m_wr < m_exp), (m_rd == m_wr), m_done, 7'(m_wr),
               m_serr, m_lerr, m_perr, m_rvld}));
      if (m_rvld) begin
        n_checks++;
        if ({rd_rresp, rd_data} !== m_rdat) begin
          n_fail++;
          $display("FAIL rd_line: got %0h expected %0h at %0t", {rd_rresp, rd_data}, m_rdat, $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    fill_start = 0; axi_rvalid = 0; axi_rlast = 0; rd_req = 0; ld = 0;
  endtask

  task automatic start(input int sz);
    idle_in();
    fill_start = 1; comp_size = 14'(sz);
    tick();
    fill_start = 0;
  endtask

  task automatic beats(input int n);
    axi_rvalid = 1;
    for (int i = 0; i < n; i++) begin
      axi_rdata = rnd512(); axi_rresp = 2'($urandom);
      tick();
    end
    axi_rvalid = 0;
  endtask

  logic [DW-1:0] line2;

  initial begin
    // reset state
    #12;
    chk("rst_rready", 64'(axi_rready), 0);
    chk("rst_empty", 64'(rdfifo_empty), 1);
    chk("rst_rd", 64'({rd_valid, rd_rresp, rd_data}), 0);
    chk("rst_flags", 64'({fill_done, fill_cnt, size_err, len_err, ptr_err}), 0);
    @(negedge clk); rst_n = 1;
    tick();

    // 200 bytes -> 4 lines, then four back-to-back reads
    start(200);
    beats(6);
    @(negedge clk);
    chk("p200_cnt", 64'(fill_cnt), 4);
    chk("p200_done", 64'(fill_done), 1);
    chk("p200_rready", 64'(axi_rready), 0);
    rd_req = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("p200_rdv", 64'(rd_valid), 1);
    end
    rd_req = 0;
    @(negedge clk);
    chk("p200_empty", 64'(rdfifo_empty), 1);

    // zero-size page completes immediately
    start(0);
    @(negedge clk);
    chk("z_done", 64'(fill_done), 1);
    chk("z_rready", 64'(axi_rready), 0);
    chk("z_empty", 64'(rdfifo_empty), 1);
    chk("z_errs", 64'({size_err, len_err, ptr_err}), 0);

    // oversize page clamps at 64 lines
    start(8000);
    beats(67);
    axi_rvalid = 1;
    @(negedge clk);
    chk("big_cnt", 64'(fill_cnt), 64);
    chk("big_serr", 64'(size_err), 1);
    chk("big_rready", 64'(axi_rready), 0);
    axi_rvalid = 0;

    // early rlast on beat 3 of an 8-line page
    start(512);
    axi_rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      axi_rdata = rnd512(); axi_rlast = (i == 2);
      tick();
    end
    idle_in();
    @(negedge clk);
    chk("rl_cnt", 64'(fill_cnt), 3);
    chk("rl_lerr", 64'(len_err), 1);
    chk("rl_done", 64'(fill_done), 1);

    // pointer load: rewind to line 2, then overrun load
    start(384);
    axi_rvalid = 1;
    for (int i = 0; i < 6; i++) begin
      axi_rdata = rnd512(); axi_rresp = 2'(i);
      if (i == 2) line2 = axi_rdata;
      tick();
    end
    axi_rvalid = 0;
    rd_req = 1;
    for (int i = 0; i < 5; i++) tick();
    ld = 1; rdfifo_rdptr = 2;
    tick();
    ld = 0; rd_req = 0;
    @(negedge clk);
    chk("ld_rdv0", 64'(rd_valid), 0);
    rd_req = 1;
    tick();
    rd_req = 0;
    @(negedge clk);
    chk("ld_line2_v", 64'(rd_valid), 1);
    chk("ld_line2_lo", rd_data[63:0], line2[63:0]);
    chk("ld_line2_rr", 64'(rd_rresp), 2);
    ld = 1; rdfifo_rdptr = 9;
    tick();
    ld = 0;
    @(negedge clk);
    chk("ld9_perr", 64'(ptr_err), 1);
    chk("ld9_empty", 64'(rdfifo_empty), 1);

    // randomized pages with streaming reads, stalls, loads, early rlast
    for (int p = 0; p < 10; p++) begin
      start(int'($urandom_range(0, 5000)));
      for (int c = 0; c < 160; c++) begin
        axi_rvalid   = ($urandom % 3) != 0;
        axi_rdata    = rnd512();
        axi_rresp    = 2'($urandom);
        axi_rlast    = ($urandom % 50) == 0;
        rd_req       = ($urandom % 2) != 0;
        ld           = ($urandom % 25) == 0;
        rdfifo_rdptr = PTRW'($urandom);
        tick();
      end
    end
    idle_in();

    // async reset mid-fill with a read in flight
    start(2000);
    beats(4);
    axi_rvalid = 1; rd_req = 1;
    tick();
    chk("ar_pre_rdv", 64'(rd_valid), 1);
    chk("ar_pre_rdy", 64'(axi_rready), 1);
    #2 rst_n = 0;
    #1;
    chk("ar_rready", 64'(axi_rready), 0);
    chk("ar_rdv", 64'(rd_valid), 0);
    chk("ar_outs", 64'({fill_done, fill_cnt, size_err, len_err, ptr_err}), 0);
    chk("ar_empty", 64'(rdfifo_empty), 1);
    chk("ar_rdata", 64'({rd_rresp, rd_data[61:0]}), 0);
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    start(130);
    beats(4);
    rd_req = 1;
    repeat (4) tick();
    idle_in();
    @(negedge clk);
    chk("post_cnt", 64'(fill_cnt), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
